// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-register pending scoreboard,
// optional write-to-read forwarding and a sequential whole-file clear sweep.
// Register 0 is hardwired to zero and can never be reserved.

module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                rsv_valid,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  // Clear sweep controller states
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  // Highest register index; the sweep ends after zeroing this one
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  // Storage and scoreboard
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;

  // Sweep controller state
  logic [0:0]    state;
  logic [0:0]    state_next;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_next;
  logic          done_next;

  // Qualified requests: address 0 is never written or reserved, and the
  // sweep owns the array exclusively while it runs.
  logic sweeping;
  logic wr_ok;
  logic rsv_ok;

  assign sweeping = (state == SWEEP);
  assign clr_busy = sweeping;
  assign wr_ok    = we && (wa != '0) && !sweeping;
  assign rsv_ok   = rsv_valid && (rsv_addr != '0) && !sweeping;

  // Next-state logic for the clear sweep (index starts at 1, reg 0 is constant)
  always_comb begin
    state_next = state;
    idx_next   = idx;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = SWEEP;
          idx_next   = AW'(1);
        end
      end
      SWEEP: begin
        if (idx == LAST_IDX) begin
          state_next = IDLE;
          idx_next   = '0;
          done_next  = 1'b1;
        end else begin
          idx_next = idx + AW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Sweep controller registers; clr_done is a registered one-cycle pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      clr_done <= done_next;
    end
  end

  // Register array: sweep zeroing takes priority, otherwise accepted writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (sweeping) begin
      regs[idx] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  // Scoreboard: a write clears its pending bit, but a reservation issued in
  // the same cycle to the same register is assigned last and therefore wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else if (sweeping) begin
      pending[idx] <= 1'b0;
    end else begin
      if (wr_ok) begin
        pending[wa] <= 1'b0;
      end
      if (rsv_ok) begin
        pending[rsv_addr] <= 1'b1;
      end
    end
  end

  // Combinational read ports with optional forwarding of the in-flight write
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = ra[i*AW +: AW];
    assign hit  = (BYPASS != 0) && wr_ok && (wa == addr);

    assign rd[i*XLEN +: XLEN] = (addr == '0) ? '0 :
                                hit          ? wd :
                                               regs[addr];

    assign rbusy[i] = pending[addr] && !hit;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb. Two instances (forwarding
// on and off) share every input and are compared against a behavioural model.

module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                we = 1'b0;
  logic [AW-1:0]       wa = '0;
  logic [XLEN-1:0]     wd = '0;
  logic [NRD*AW-1:0]   ra = '0;
  logic                rsv_valid = 1'b0;
  logic [AW-1:0]       rsv_addr = '0;
  logic                clr_req = 1'b0;

  logic [NRD*XLEN-1:0] rd_b, rd_n;
  logic [NRD-1:0]      rbusy_b, rbusy_n;
  logic                clr_busy_b, clr_busy_n;
  logic                clr_done_b, clr_done_n;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd_b), .rbusy(rbusy_b), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd_n), .rbusy(rbusy_n), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(clr_busy_n), .clr_done(clr_done_n)
  );

  always #5 clk = ~clk;

  // Behavioural model: register contents, pending flags, and the number of
  // sweep cycles still to run (the register cleared is NREGS - remaining).
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_pend [NREGS];
  int              m_left;
  bit              m_done;

  task automatic m_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    m_left = 0;
    m_done = 1'b0;
  endtask

  task automatic m_edge();
    bit nd;
    nd = 1'b0;
    if (m_left > 0) begin
      m_regs[NREGS - m_left] = '0;
      m_pend[NREGS - m_left] = 1'b0;
      m_left--;
      if (m_left == 0) nd = 1'b1;
    end else begin
      if (we && wa != 0) begin
        m_regs[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
      if (clr_req) m_left = NREGS - 1;
    end
    m_done = nd;
  endtask

  function automatic logic [XLEN-1:0] m_rd(input bit byp, input int addr);
    if (addr == 0) return '0;
    if (byp && m_left == 0 && we && int'(wa) == addr) return wd;
    return m_regs[addr];
  endfunction

  function automatic bit m_rbusy(input bit byp, input int addr);
    if (addr == 0) return 1'b0;
    if (byp && m_left == 0 && we && int'(wa) == addr) return 1'b0;
    return m_pend[addr];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every output of both instances against the model
  task automatic check_output(input string tag);
    for (int p = 0; p < NRD; p++) begin
      int addr;
      addr = int'(ra[p*AW +: AW]);
      check($sformatf("%s rd%0d byp a=%0d", tag, p, addr), rd_b[p*XLEN +: XLEN], m_rd(1'b1, addr));
      check($sformatf("%s rbusy%0d byp a=%0d", tag, p, addr), rbusy_b[p], m_rbusy(1'b1, addr));
      check($sformatf("%s rd%0d nobyp a=%0d", tag, p, addr), rd_n[p*XLEN +: XLEN], m_rd(1'b0, addr));
      check($sformatf("%s rbusy%0d nobyp a=%0d", tag, p, addr), rbusy_n[p], m_rbusy(1'b0, addr));
    end
    check({tag, " clr_busy byp"}, clr_busy_b, m_left > 0);
    check({tag, " clr_busy nobyp"}, clr_busy_n, m_left > 0);
    check({tag, " clr_done byp"}, clr_done_b, m_done);
    check({tag, " clr_done nobyp"}, clr_done_n, m_done);
  endtask

  task automatic apply_stimulus(input bit i_we, input int i_wa, input logic [XLEN-1:0] i_wd,
                                input int i_ra0, input int i_ra1, input bit i_rsv,
                                input int i_rsva, input bit i_clr);
    we        = i_we;
    wa        = AW'(i_wa);
    wd        = i_wd;
    ra        = {AW'(i_ra1), AW'(i_ra0)};
    rsv_valid = i_rsv;
    rsv_addr  = AW'(i_rsva);
    clr_req   = i_clr;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    #1;
    check_output(tag);
    finish_cycle();
  endtask

  typedef struct {
    bit              v_we;
    int              v_wa;
    logic [XLEN-1:0] v_wd;
    int              v_ra0;
    int              v_ra1;
    bit              v_rsv;
    int              v_rsva;
    logic [XLEN-1:0] e_rd0;
    logic [XLEN-1:0] e_rd1;
    logic [1:0]      e_rbusy;
    logic [XLEN-1:0] n_rd0;
    logic [XLEN-1:0] n_rd1;
    logic [1:0]      n_rbusy;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int busy_cnt;
    int done_cnt;

    // Directed vectors applied back to back from the reset state
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00};
    vecs[1]  = '{1, 0, 32'h00001234, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0, 2'b00, 32'hDEADBEEF, 32'h0, 2'b00};
    vecs[2]  = '{0, 0, 32'h0, 0, 5, 1, 3, 32'h0, 32'hDEADBEEF, 2'b00, 32'h0, 32'hDEADBEEF, 2'b00};
    vecs[3]  = '{0, 0, 32'h0, 3, 5, 0, 0, 32'h0, 32'hDEADBEEF, 2'b01, 32'h0, 32'hDEADBEEF, 2'b01};
    vecs[4]  = '{1, 3, 32'h11112222, 3, 7, 0, 0, 32'h11112222, 32'h0, 2'b00, 32'h0, 32'h0, 2'b01};
    vecs[5]  = '{0, 0, 32'h0, 3, 3, 0, 0, 32'h11112222, 32'h11112222, 2'b00, 32'h11112222, 32'h11112222, 2'b00};
    vecs[6]  = '{1, 3, 32'h33334444, 3, 0, 1, 3, 32'h33334444, 32'h0, 2'b00, 32'h11112222, 32'h0, 2'b00};
    vecs[7]  = '{0, 0, 32'h0, 3, 0, 0, 0, 32'h33334444, 32'h0, 2'b01, 32'h33334444, 32'h0, 2'b01};
    vecs[8]  = '{1, 7, 32'hA5A5A5A5, 5, 7, 0, 0, 32'hDEADBEEF, 32'hA5A5A5A5, 2'b00, 32'hDEADBEEF, 32'h0, 2'b00};
    vecs[9]  = '{0, 0, 32'h0, 0, 7, 1, 0, 32'h0, 32'hA5A5A5A5, 2'b00, 32'h0, 32'hA5A5A5A5, 2'b00};
    vecs[10] = '{0, 0, 32'h0, 0, 7, 0, 0, 32'h0, 32'hA5A5A5A5, 2'b00, 32'h0, 32'hA5A5A5A5, 2'b00};

    // Reset state
    m_reset();
    apply_stimulus(0, 0, '0, 5, 31, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("reset");
    check("reset rd", rd_b, '0);
    check("reset clr_busy", clr_busy_b, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven directed vectors
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].v_we, vecs[i].v_wa, vecs[i].v_wd, vecs[i].v_ra0, vecs[i].v_ra1,
                     vecs[i].v_rsv, vecs[i].v_rsva, 0);
      #1;
      check($sformatf("vec%0d rd0", i), rd_b[XLEN-1:0], vecs[i].e_rd0);
      check($sformatf("vec%0d rd1", i), rd_b[2*XLEN-1:XLEN], vecs[i].e_rd1);
      check($sformatf("vec%0d rbusy", i), rbusy_b, vecs[i].e_rbusy);
      check($sformatf("vec%0d nobyp rd0", i), rd_n[XLEN-1:0], vecs[i].n_rd0);
      check($sformatf("vec%0d nobyp rd1", i), rd_n[2*XLEN-1:XLEN], vecs[i].n_rd1);
      check($sformatf("vec%0d nobyp rbusy", i), rbusy_n, vecs[i].n_rbusy);
      check_output($sformatf("vec%0d", i));
      finish_cycle();
    end

    // Sweep 1: fill, clear, ignored clr_req and dropped write mid-sweep
    for (int a = 1; a < NREGS; a++) begin
      apply_stimulus(1, a, $urandom | 32'h1, a, (a + 1) % NREGS, (a % 3) == 0, a, 0);
      step("fill1");
    end
    apply_stimulus(0, 0, '0, 1, 31, 0, 0, 1);
    step("clr1 req");
    busy_cnt = 0;
    done_cnt = 0;
    for (int it = 0; it < 40; it++) begin
      apply_stimulus(it == 10, 3, 32'hFFFFFFFF, it % NREGS, 3, it == 10, 4, it == 5);
      #1;
      if (clr_busy_b) busy_cnt++;
      if (clr_done_b) done_cnt++;
      check_output("sweep1");
      finish_cycle();
    end
    check("sweep1 busy cycles", busy_cnt, 31);
    check("sweep1 done pulses", done_cnt, 1);
    for (int a = 0; a < NREGS; a += 2) begin
      apply_stimulus(0, 0, '0, a, a + 1, 0, 0, 0);
      #1;
      check($sformatf("after sweep1 rd a=%0d", a), rd_b, '0);
      check($sformatf("after sweep1 rbusy a=%0d", a), rbusy_b, 2'b00);
      check_output("after sweep1");
      finish_cycle();
    end

    // Sweep 2: clr_req in the clr_done cycle restarts immediately
    for (int a = 1; a < NREGS; a += 3) begin
      apply_stimulus(1, a, $urandom | 32'h1, 0, a, 0, 0, 0);
      step("fill2");
    end
    apply_stimulus(0, 0, '0, 2, 30, 0, 0, 1);
    step("clr2 req");
    busy_cnt = 0;
    done_cnt = 0;
    for (int it = 0; it < 70; it++) begin
      apply_stimulus(0, 0, '0, it % NREGS, 31, 0, 0, it == 31);
      #1;
      if (it == 31) check("sweep2 done before restart", clr_done_b, 1'b1);
      if (it == 32) check("sweep2 restarted", clr_busy_b, 1'b1);
      if (clr_busy_b) busy_cnt++;
      if (clr_done_b) done_cnt++;
      check_output("sweep2");
      finish_cycle();
    end
    check("sweep2 busy cycles", busy_cnt, 62);
    check("sweep2 done pulses", done_cnt, 2);

    // Sweep 3: reset asserted at sweep cycle 10 aborts everything
    for (int a = 1; a < NREGS; a++) begin
      apply_stimulus(1, a, $urandom | 32'h100, a, 0, a >= 20, a, 0);
      step("fill3");
    end
    apply_stimulus(0, 0, '0, 31, 20, 0, 0, 1);
    step("clr3 req");
    for (int it = 0; it < 10; it++) begin
      apply_stimulus(0, 0, '0, 31, 20, 0, 0, 0);
      step("sweep3");
    end
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    check("abort rd", rd_b, '0);
    check("abort rbusy", rbusy_b, 2'b00);
    check("abort clr_busy", clr_busy_b, 1'b0);
    check("abort clr_done", clr_done_b, 1'b0);
    check_output("abort");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    done_cnt = 0;
    for (int a = 0; a < NREGS; a += 2) begin
      apply_stimulus(0, 0, '0, a, a + 1, 0, 0, 0);
      #1;
      if (clr_done_b) done_cnt++;
      check($sformatf("after abort rd a=%0d", a), rd_b, '0);
      check($sformatf("after abort rbusy a=%0d", a), rbusy_b, 2'b00);
      check_output("after abort");
      finish_cycle();
    end
    for (int it = 0; it < 20; it++) begin
      apply_stimulus(0, 0, '0, it, 31 - it, 0, 0, 0);
      #1;
      if (clr_done_b) done_cnt++;
      finish_cycle();
    end
    check("abort no clr_done", done_cnt, 0);

    // Randomized traffic against the model
    for (int it = 0; it < 500; it++) begin
      int w_a;
      w_a = $urandom_range(0, NREGS - 1);
      apply_stimulus($urandom_range(0, 1), w_a, $urandom,
                     ($urandom_range(0, 3) == 0) ? w_a : $urandom_range(0, NREGS - 1),
                     ($urandom_range(0, 3) == 0) ? w_a : $urandom_range(0, NREGS - 1),
                     $urandom_range(0, 2) == 0,
                     ($urandom_range(0, 3) == 0) ? w_a : $urandom_range(0, NREGS - 1),
                     $urandom_range(0, 59) == 0);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, register data width in bits.
REQ-002 SHALL provide parameter NREGS, default 32, register count (power of two, >=4); AW = clog2(NREGS).
REQ-003 SHALL provide parameter NRD, default 2, number of read ports.
REQ-004 SHALL provide parameter BYPASS, default 1, enabling write-to-read forwarding when 1.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 we  input  1  write enable.
REQ-008 wa  input  AW  write address.
REQ-009 wd  input  XLEN  write data.
REQ-010 ra  input  NRD*AW  packed read addresses, port i at bits [i*AW +: AW].
REQ-011 rd  output  NRD*XLEN  packed read data, port i at bits [i*XLEN +: XLEN].
REQ-012 rbusy  output  NRD  per-port pending flag for the addressed register.
REQ-013 rsv_valid  input  1  reserve request: mark rsv_addr as pending a write.
REQ-014 rsv_addr  input  AW  register to reserve.
REQ-015 clr_req  input  1  request sequential zeroing of the whole file.
REQ-016 clr_busy  output  1  high while a clear sweep is in progress.
REQ-017 clr_done  output  1  one-cycle pulse when a clear sweep finishes.

Function
REQ-018 Register 0 SHALL read as 0 on every port; writes, reservations and pending state for address 0 SHALL be ignored (rbusy 0).
REQ-019 Reads SHALL be combinational: rd[i] = regs[ra[i]].
REQ-020 With BYPASS=1, if we=1, wa!=0, wa==ra[i] and clr_busy=0, rd[i] SHALL equal wd in the same cycle; with BYPASS=0, rd[i] shows the old value until the next edge.
REQ-021 A write SHALL update regs[wa] on the rising edge when we=1, wa!=0, clr_busy=0.
REQ-022 Scoreboard: pending[rsv_addr] SHALL set on the edge when rsv_valid=1, rsv_addr!=0, clr_busy=0.
REQ-023 pending[wa] SHALL clear on the edge of an accepted write.
REQ-024 Simultaneous reserve and write to the same address: set SHALL win (pending stays 1, data still written).
REQ-025 rbusy[i] SHALL equal pending[ra[i]]; with BYPASS=1, rbusy[i] SHALL be 0 when an accepted write to ra[i] is present in the same cycle.
REQ-026 Clear FSM states IDLE and SWEEP; IDLE->SWEEP on clr_req=1, with index counter loaded to 1.
REQ-027 In SWEEP, each cycle SHALL zero regs[index] and clear pending[index], then increment index.
REQ-028 SWEEP->IDLE on the edge that processes index NREGS-1; clr_done SHALL pulse high for the one cycle following that edge.
REQ-029 Sweep length SHALL be exactly NREGS-1 cycles of clr_busy=1 (31 at default).
REQ-030 clr_busy SHALL be 1 exactly in SWEEP; clr_req while in SWEEP SHALL be ignored (no restart).
REQ-031 Writes and reservations during SWEEP SHALL be dropped; reads return current array contents (partially cleared).
REQ-032 clr_req arriving in the same cycle as clr_done SHALL start a new sweep.

Reset
REQ-033 reset=0 SHALL asynchronously zero all registers and pending bits, force the FSM to IDLE, index to 0, clr_busy and clr_done to 0.
REQ-034 reset asserted mid-sweep SHALL abort the sweep with no clr_done pulse.
REQ-035 After reset release, the first rising edge SHALL accept writes and reservations.

Verification
REQ-036 Write wa=5 wd=0xDEADBEEF, next cycle ra[0]=5 -> rd[0]=0xDEADBEEF; write wa=0 wd=0x1234 -> ra=0 reads 0.
REQ-037 BYPASS=1: we=1 wa=7 wd=0xA5A5A5A5 with ra[1]=7 in same cycle -> rd[1]=0xA5A5A5A5 before the edge; BYPASS=0 -> old value.
REQ-038 rsv_valid rsv_addr=3 -> rbusy=1 for ra=3 next cycle; write wa=3 -> rbusy=0 after the edge; reserve+write to 3 together -> rbusy stays 1.
REQ-039 Fill regs 1..31 with nonzero data, pulse clr_req -> clr_busy high 31 cycles, clr_done one pulse, all reads 0, write attempted mid-sweep not retained.
REQ-040 Assert reset=0 at sweep cycle 10 -> all outputs 0 immediately, no clr_done, all registers and pending bits read 0.
